led_scanner: RTL and testbench

Parametrised LED scanner for the board LED bank, and the successor to the fixed 10-LED single-dot scanner.
- Generalised in LED count, step period and trail length.
- Adds run-time modes (bounce, wrap-up, wrap-down, hold), an enable input and a fading-trail display.
- Sits between CLOCK_50 and LEDR at top level, and replaces the divided-clock design with a single-clock tick-enable design.

---
 rtl/led_pkg.sv | 20 ++
 rtl/tick_gen.sv | 38 +++
 rtl/led_scanner.sv | 121 ++++++++++++
 tb/tb_led_scanner.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module : led_pkg
//  Brief  : Shared mode encodings and width helper for the LED display blocks.
//  Rev    : 1.0  initial release
// ============================================================================
package led_pkg;

    localparam logic [1:0] MODE_BOUNCE  = 2'd0;
    localparam logic [1:0] MODE_WRAP_UP = 2'd1;
    localparam logic [1:0] MODE_WRAP_DN = 2'd2;
    localparam logic [1:0] MODE_HOLD    = 2'd3;

    // Index width for n items, never narrower than one bit.
    function automatic int pos_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : led_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module : tick_gen
//  Brief  : Single-clock tick-enable generator; one-cycle tick every TICK_DIV
//           enabled cycles.
//  Rev    : 1.0  initial release
// ============================================================================
module tick_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = 2500000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic enable,
    output logic tick
);

    localparam int            CW     = pos_width(TICK_DIV);
    localparam logic [CW-1:0] c_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == c_LAST);
    // Combinational so the consumer's registered step lines up with its state.
    assign tick      = enable && w_at_last;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_at_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule : tick_gen
`default_nettype wire

// File: rtl/led_scanner.sv
`default_nettype none
// ============================================================================
//  Module : led_scanner
//  Brief  : Parametrised LED scanner with bounce/wrap/hold modes and a fading
//           trail display, driven from a single-clock tick enable.
//  Rev    : 1.0  initial release
// ============================================================================
module led_scanner
    import led_pkg::*;
#(
    parameter int NUM_LEDS  = 10,
    parameter int TICK_DIV  = 2500000,
    parameter int TRAIL_LEN = 3
) (
    input  logic                            CLOCK_50,
    input  logic                            RESET,
    input  logic                            enable,
    input  logic [1:0]                      mode,
    output logic [NUM_LEDS-1:0]             LEDR,
    output logic [pos_width(NUM_LEDS)-1:0]  pos,
    output logic                            dir_up,
    output logic                            step
);

    localparam int                W        = pos_width(NUM_LEDS);
    localparam logic [W-1:0]      c_LAST   = W'(NUM_LEDS - 1);
    localparam logic [W-1:0]      c_PENULT = W'(NUM_LEDS - 2);
    localparam logic [W-1:0]      c_ONE    = W'(1);
    localparam logic [NUM_LEDS-1:0] c_LED0 = NUM_LEDS'(1);

    logic                w_tick;
    logic [W-1:0]        r_hist [TRAIL_LEN];
    logic                r_dir_up;
    logic                r_step;
    logic [NUM_LEDS-1:0] r_ledr;

    logic [W-1:0]        w_pos;
    logic [W-1:0]        w_pos_nxt;
    logic                w_dir_nxt;
    logic [NUM_LEDS-1:0] w_ledr_nxt;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .enable   (enable),
        .tick     (w_tick)
    );

    // The head of the history is the current position.
    assign w_pos = r_hist[0];

    always_comb begin
        w_pos_nxt = w_pos;
        w_dir_nxt = r_dir_up;
        case (mode)
            MODE_BOUNCE: begin
                if (r_dir_up && (w_pos == c_LAST)) begin
                    w_dir_nxt = 1'b0;
                    w_pos_nxt = c_PENULT;
                end else if (!r_dir_up && (w_pos == '0)) begin
                    w_dir_nxt = 1'b1;
                    w_pos_nxt = c_ONE;
                end else if (r_dir_up) begin
                    w_pos_nxt = w_pos + c_ONE;
                end else begin
                    w_pos_nxt = w_pos - c_ONE;
                end
            end
            MODE_WRAP_UP: begin
                w_dir_nxt = 1'b1;
                w_pos_nxt = (w_pos == c_LAST) ? '0 : w_pos + c_ONE;
            end
            MODE_WRAP_DN: begin
                w_dir_nxt = 1'b0;
                w_pos_nxt = (w_pos == '0) ? c_LAST : w_pos - c_ONE;
            end
            default: begin
                w_pos_nxt = w_pos;
                w_dir_nxt = r_dir_up;
            end
        endcase
    end

    // Decode the post-shift history: new head plus all but the oldest entry.
    always_comb begin
        w_ledr_nxt = c_LED0 << w_pos_nxt;
        for (int i = 0; i < TRAIL_LEN - 1; i++) begin
            w_ledr_nxt = w_ledr_nxt | (c_LED0 << r_hist[i]);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            for (int i = 0; i < TRAIL_LEN; i++) begin
                r_hist[i] <= '0;
            end
            r_dir_up <= 1'b1;
            r_step   <= 1'b0;
            r_ledr   <= c_LED0;
        end else begin
            r_step <= w_tick;
            if (w_tick) begin
                r_hist[0] <= w_pos_nxt;
                for (int i = 1; i < TRAIL_LEN; i++) begin
                    r_hist[i] <= r_hist[i-1];
                end
                r_dir_up <= w_dir_nxt;
                r_ledr   <= w_ledr_nxt;
            end
        end
    end

    assign pos    = w_pos;
    assign dir_up = r_dir_up;
    assign step   = r_step;
    assign LEDR   = r_ledr;

endmodule : led_scanner
`default_nettype wire

// File: tb/tb_led_scanner.sv
`default_nettype none
// ============================================================================
//  Module : tb_led_scanner
//  Brief  : Directed self-checking bench for led_scanner (4-LED trail-2 and
//           5-LED single-dot instances).
//  Rev    : 1.0  initial release
// ============================================================================
module tb_led_scanner;
    import led_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] md;

    logic [3:0] ledr4;
    logic [1:0] pos4;
    logic       dir4;
    logic       step4;

    logic [4:0] ledr5;
    logic [2:0] pos5;
    logic       dir5;
    logic       step5;

    int n_vec  = 0;
    int n_err  = 0;
    int bad5   = 0;

    always #5 clk = ~clk;

    led_scanner #(
        .NUM_LEDS  (4),
        .TICK_DIV  (3),
        .TRAIL_LEN (2)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .enable   (en),
        .mode     (md),
        .LEDR     (ledr4),
        .pos      (pos4),
        .dir_up   (dir4),
        .step     (step4)
    );

    led_scanner #(
        .NUM_LEDS  (5),
        .TICK_DIV  (3),
        .TRAIL_LEN (1)
    ) dut5 (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .enable   (en),
        .mode     (md),
        .LEDR     (ledr5),
        .pos      (pos5),
        .dir_up   (dir5),
        .step     (step5)
    );

    always @(negedge clk) begin
        if (!$onehot(ledr5)) bad5++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Two quiet cycles then the step cycle.
    task automatic do_step(input string tag);
        logic early;
        cyc();
        early = step4;
        cyc();
        early = early | step4;
        chk({tag, "_quiet"}, 32'(early), 32'd0);
        cyc();
        chk({tag, "_step"}, 32'(step4), 32'd1);
    endtask

    int b_pos  [7] = '{1, 2, 3, 2, 1, 0, 1};
    int b_ledr [7] = '{4'b0011, 4'b0110, 4'b1100, 4'b1100, 4'b0110, 4'b0011, 4'b0011};
    int b_dir  [7] = '{1, 1, 1, 0, 0, 0, 1};
    int u_pos  [5] = '{1, 2, 3, 0, 1};
    int f_pos  [9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};

    initial begin
        logic frz;

        // Reset state, bounce scan
        rst = 1'b1; en = 1'b1; md = MODE_BOUNCE;
        cyc(); cyc();
        chk("rst_ledr", 32'(ledr4), 32'd1);
        chk("rst_pos",  32'(pos4),  32'd0);
        chk("rst_dir",  32'(dir4),  32'd1);
        chk("rst_step", 32'(step4), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            do_step("bounce");
            chk("bounce_pos",  32'(pos4),  32'(b_pos[i]));
            chk("bounce_ledr", 32'(ledr4), 32'(b_ledr[i]));
            chk("bounce_dir",  32'(dir4),  32'(b_dir[i]));
        end

        // Wrap-up then wrap-down
        rst = 1'b1; md = MODE_WRAP_UP;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_step("wup");
            chk("wup_pos", 32'(pos4), 32'(u_pos[i]));
            if (i == 3) chk("wup_ledr_wrap", 32'(ledr4), 32'b1001);
        end
        md = MODE_WRAP_DN;
        do_step("wdn");
        chk("wdn_pos0",  32'(pos4),  32'd0);
        chk("wdn_ledr0", 32'(ledr4), 32'b0011);
        do_step("wdn");
        chk("wdn_pos3",  32'(pos4),  32'd3);
        chk("wdn_ledr3", 32'(ledr4), 32'b1001);
        chk("wdn_dir",   32'(dir4),  32'd0);

        // Hold at pos 2 after an upward move
        rst = 1'b1; md = MODE_WRAP_UP;
        cyc();
        rst = 1'b0;
        do_step("pre_hold");
        do_step("pre_hold");
        chk("pre_hold_pos", 32'(pos4), 32'd2);
        md = MODE_HOLD;
        do_step("hold");
        chk("hold_ledr", 32'(ledr4), 32'b0100);
        chk("hold_pos",  32'(pos4),  32'd2);
        do_step("hold2");
        chk("hold2_pos", 32'(pos4), 32'd2);
        chk("hold2_dir", 32'(dir4), 32'd1);

        // Enable dropped while the counter sits at its last value
        md = MODE_WRAP_UP;
        cyc(); cyc();
        en = 1'b0;
        frz = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            frz = frz | step4 | (pos4 != 2'd2) | (ledr4 != 4'b0100);
        end
        chk("freeze", 32'(frz), 32'd0);
        en = 1'b1;
        cyc();
        chk("resume_step", 32'(step4), 32'd1);
        chk("resume_pos",  32'(pos4),  32'd3);
        chk("resume_ledr", 32'(ledr4), 32'b1100);

        // One-cycle reset mid-scan at pos 3
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mrst_pos",  32'(pos4),  32'd0);
        chk("mrst_dir",  32'(dir4),  32'd1);
        chk("mrst_ledr", 32'(ledr4), 32'd1);
        chk("mrst_step", 32'(step4), 32'd0);
        do_step("mrst_restart");
        chk("mrst_next_pos", 32'(pos4), 32'd1);

        // Five LEDs, single dot, bounce
        rst = 1'b1; md = MODE_BOUNCE;
        cyc();
        rst = 1'b0;
        chk("dot_rst_ledr", 32'(ledr5), 32'd1);
        for (int i = 0; i < 9; i++) begin
            do_step("dot");
            chk("dot_step", 32'(step5), 32'd1);
            chk("dot_pos",  32'(pos5),  32'(f_pos[i]));
            chk("dot_ledr", 32'(ledr5), 32'd1 << f_pos[i]);
        end
        chk("dot_onehot", 32'(bad5), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_led_scanner
`default_nettype wire
